// File: rtl/opamp_sar_pkg.sv
// opamp_sar_pkg: shared types, default parameters and helpers for the SAR controller
package opamp_sar_pkg;
  typedef enum logic {IDLE, CONVERT} state_t;
  localparam int WIDTH_DEF = 8;
  localparam int SETTLE_DEF = 4;
  localparam int SYNC_DEF = 2;
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/opamp_sync.sv
// opamp_sync: STAGES-deep flop synchronizer for the asynchronous comparator output
// Ports: clk, rst (sync, active-high, clears all stages), d (async in), q (synchronized out)
module opamp_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk)
    ff <= rst ? '0 : {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/opamp_sar_ctrl.sv
// opamp_sar_ctrl: successive-approximation controller driving a reference DAC against an opamp comparator
// Ports: wb_clk_i clock; wb_rst_i sync active-high reset; start_i request (sampled in IDLE);
//   cmp_i async comparator (low when input above trial); cmp_en_o comparator power gate;
//   dac_o trial code; busy_o converting; done_o one-cycle completion pulse; result_o last code.
// Option: define OPAMP_SAR_VOTE_EN to take each bit decision as a 2-of-3 majority of the
//   last three synchronized comparator samples of the slot instead of the final sample alone.
module opamp_sar_ctrl
  import opamp_sar_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF,
  parameter int SYNC_STAGES = SYNC_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  logic             cmp_i,
  output logic             cmp_en_o,
  output logic [WIDTH-1:0] dac_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int S = SETTLE_CYCLES + SYNC_STAGES;
  localparam int CW = cnt_width(S);
  localparam int IW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(S - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic cmp_s, d;
  logic [WIDTH-1:0] kept;
  opamp_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .d(cmp_i),
    .q(cmp_s)
  );
`ifdef OPAMP_SAR_VOTE_EN
  logic [1:0] votes;
  always_ff @(posedge wb_clk_i)
    votes <= wb_rst_i ? '0 : {cnt == CW'(S - 2) ? cmp_s : votes[1], cnt == CW'(S - 3) ? cmp_s : votes[0]};
  assign d = (votes[0] & votes[1]) | (cmp_s & (votes[0] | votes[1]));
`else
  assign d = cmp_s;
`endif
  // a high decision means the trial overshot the input, so the bit under test is dropped
  assign kept = d ? dac_o & ~(WIDTH'(1) << idx) : dac_o;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      dac_o <= '0;
      result_o <= '0;
      done_o <= 1'b0;
      busy_o <= 1'b0;
      cmp_en_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          state <= CONVERT;
          dac_o <= WIDTH'(1) << (WIDTH - 1);
          idx <= IW'(WIDTH - 1);
          cnt <= '0;
          busy_o <= 1'b1;
          cmp_en_o <= 1'b1;
        end
        CONVERT: if (cnt != LAST) begin
          cnt <= cnt + 1'b1;
        end else if (idx != '0) begin
          dac_o <= kept | (WIDTH'(1) << (idx - 1'b1));
          idx <= idx - 1'b1;
          cnt <= '0;
        end else begin
          result_o <= kept;
          done_o <= 1'b1;
          busy_o <= 1'b0;
          cmp_en_o <= 1'b0;
          dac_o <= '0;
          cnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
